// File: rtl/mem_access_unit_if.sv
// Bundle between the MEM stage, the memory access unit and its word-wide synchronous SRAM.
// The slave modport is the unit itself. The master modport is the pipeline together with the SRAM.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [1:0]            MemRead;
    logic [1:0]            MemWrite;
    logic [31:0]           Address;
    logic [31:0]           WriteData;
    logic                  Stall;
    logic [31:0]           ReadData;
    logic                  ReadValid;
    logic                  AlignErr;
    logic                  SramEn;
    logic [3:0]            SramWe;
    logic [ADDR_WIDTH-1:0] SramAddr;
    logic [31:0]           SramWData;
    logic [31:0]           SramRData;

    modport slave (
        input  MemRead, MemWrite, Address, WriteData, SramRData,
        output Stall, ReadData, ReadValid, AlignErr,
        output SramEn, SramWe, SramAddr, SramWData
    );

    modport master (
        output MemRead, MemWrite, Address, WriteData, SramRData,
        input  Stall, ReadData, ReadValid, AlignErr,
        input  SramEn, SramWe, SramAddr, SramWData
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory responder: steers byte/half/word loads and stores onto a 32-bit
// synchronous SRAM, rejects misaligned or conflicting accesses, and stalls the pipeline meanwhile.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic             Clk,
    input  logic             Reset_n,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic       op_read;
    logic [1:0] ld_size;
    logic [1:0] ld_lane;

    logic       req;
    logic       err;
    logic [1:0] acc_size;
    logic       unused_addr;

    function automatic logic [3:0] store_we(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] we;
        case (size)
            2'b01:   we = 4'b0001 << lane;
            2'b10:   we = 4'b0011 << {lane[1], 1'b0};
            2'b11:   we = 4'b1111;
            default: we = 4'b0000;
        endcase
        return we;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            2'b01:   d = {4{wdata[7:0]}};
            2'b10:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic signed [31:0] load_extract(input logic [31:0] word,
                                                        input logic [1:0]  size,
                                                        input logic [1:0]  lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b01:   r = {{24{b[7]}}, b};
            2'b10:   r = {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_comb begin
        req      = (bus.MemRead != 2'b00) || (bus.MemWrite != 2'b00);
        acc_size = bus.MemRead | bus.MemWrite;
        err      = ((bus.MemRead != 2'b00) && (bus.MemWrite != 2'b00))
                || ((acc_size == 2'b10) && bus.Address[0])
                || ((acc_size == 2'b11) && (bus.Address[1:0] != 2'b00));
    end

    // Address bits above the SRAM depth simply wrap.
    assign unused_addr = ^bus.Address[31:ADDR_WIDTH+2];

    assign bus.Stall = Reset_n && (((state == IDLE) && req) || (state == ISSUE) || (state == WAIT));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            op_read       <= 1'b0;
            ld_size       <= 2'b00;
            ld_lane       <= 2'b00;
            bus.SramEn    <= 1'b0;
            bus.SramWe    <= 4'b0000;
            bus.SramAddr  <= '0;
            bus.SramWData <= 32'h0;
            bus.ReadData  <= 32'h0;
            bus.ReadValid <= 1'b0;
            bus.AlignErr  <= 1'b0;
        end else begin
            bus.SramEn    <= 1'b0;
            bus.SramWe    <= 4'b0000;
            bus.ReadValid <= 1'b0;
            bus.AlignErr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (err) begin
                            bus.AlignErr <= 1'b1;
                            state        <= RESP;
                        end else begin
                            bus.SramEn   <= 1'b1;
                            bus.SramAddr <= bus.Address[ADDR_WIDTH+1:2];
                            op_read      <= (bus.MemRead != 2'b00);
                            ld_size      <= bus.MemRead;
                            ld_lane      <= bus.Address[1:0];
                            if (bus.MemWrite != 2'b00) begin
                                bus.SramWe    <= store_we(bus.MemWrite, bus.Address[1:0]);
                                bus.SramWData <= store_data(bus.MemWrite, bus.WriteData);
                            end
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= op_read ? WAIT : RESP;
                WAIT: begin
                    bus.ReadData  <= load_extract(bus.SramRData, ld_size, ld_lane);
                    bus.ReadValid <= 1'b1;
                    state         <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural synchronous SRAM.
module tb_mem_access_unit;
    localparam int AW = 10;

    logic Clk = 1'b0;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [0:(1<<AW)-1];
    logic        mem_ready = 1'b0;

    always #5 Clk = ~Clk;

    mem_access_unit_if #(.ADDR_WIDTH(AW)) bus ();

    mem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    // Byte-enabled synchronous SRAM; read data appears the cycle after the strobe.
    always @(posedge Clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= 32'h0;
            mem[4]        <= 32'h8899AABB;
            bus.SramRData <= 32'h0;
            mem_ready     <= 1'b1;
        end else if (bus.SramEn) begin
            if (bus.SramWe == 4'b0000) bus.SramRData <= mem[bus.SramAddr];
            else
                for (int i = 0; i < 4; i++)
                    if (bus.SramWe[i]) mem[bus.SramAddr][8*i +: 8] <= bus.SramWData[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " Stall"},     32'(bus.Stall),     32'h0);
        check({tag, " SramEn"},    32'(bus.SramEn),    32'h0);
        check({tag, " SramWe"},    32'(bus.SramWe),    32'h0);
        check({tag, " SramAddr"},  32'(bus.SramAddr),  32'h0);
        check({tag, " SramWData"}, bus.SramWData,      32'h0);
        check({tag, " ReadData"},  bus.ReadData,       32'h0);
        check({tag, " ReadValid"}, 32'(bus.ReadValid), 32'h0);
        check({tag, " AlignErr"},  32'(bus.AlignErr),  32'h0);
    endtask

    task automatic clear_inputs();
        bus.MemRead   = 2'b00;
        bus.MemWrite  = 2'b00;
        bus.Address   = 32'h0;
        bus.WriteData = 32'h0;
    endtask

    // Called just after a rising edge with the unit idle; returns in the same phase of T+4.
    task automatic run_load(input string tag, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] exp_addr, input logic [31:0] exp_data);
        bus.MemRead = size;
        bus.Address = addr;
        @(negedge Clk);
        check({tag, " stall T"},   32'(bus.Stall),     32'h1);
        check({tag, " en T"},      32'(bus.SramEn),    32'h0);
        @(negedge Clk);
        check({tag, " stall T1"},  32'(bus.Stall),     32'h1);
        check({tag, " en T1"},     32'(bus.SramEn),    32'h1);
        check({tag, " we T1"},     32'(bus.SramWe),    32'h0);
        check({tag, " addr T1"},   32'(bus.SramAddr),  exp_addr);
        @(negedge Clk);
        check({tag, " stall T2"},  32'(bus.Stall),     32'h1);
        check({tag, " en T2"},     32'(bus.SramEn),    32'h0);
        check({tag, " valid T2"},  32'(bus.ReadValid), 32'h0);
        @(negedge Clk);
        check({tag, " stall T3"},  32'(bus.Stall),     32'h0);
        check({tag, " valid T3"},  32'(bus.ReadValid), 32'h1);
        check({tag, " data T3"},   bus.ReadData,       exp_data);
        clear_inputs();
        @(posedge Clk); #1;
        check({tag, " valid T4"},  32'(bus.ReadValid), 32'h0);
    endtask

    task automatic run_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] exp_we,
                             input logic [31:0] exp_wd, input logic [31:0] exp_addr,
                             input logic [31:0] keep_rd);
        bus.MemWrite  = size;
        bus.Address   = addr;
        bus.WriteData = wdata;
        @(negedge Clk);
        check({tag, " stall T"},   32'(bus.Stall),     32'h1);
        @(negedge Clk);
        check({tag, " stall T1"},  32'(bus.Stall),     32'h1);
        check({tag, " en T1"},     32'(bus.SramEn),    32'h1);
        check({tag, " we T1"},     32'(bus.SramWe),    32'(exp_we));
        check({tag, " wdata T1"},  bus.SramWData,      exp_wd);
        check({tag, " addr T1"},   32'(bus.SramAddr),  exp_addr);
        @(negedge Clk);
        check({tag, " stall T2"},  32'(bus.Stall),     32'h0);
        check({tag, " en T2"},     32'(bus.SramEn),    32'h0);
        check({tag, " we T2"},     32'(bus.SramWe),    32'h0);
        check({tag, " valid T2"},  32'(bus.ReadValid), 32'h0);
        check({tag, " rdata T2"},  bus.ReadData,       keep_rd);
        clear_inputs();
        @(posedge Clk); #1;
    endtask

    task automatic run_err(input string tag, input logic [1:0] rd, input logic [1:0] wr,
                           input logic [31:0] addr, input logic [31:0] keep_rd);
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.Address  = addr;
        @(negedge Clk);
        check({tag, " stall T"},   32'(bus.Stall),     32'h1);
        check({tag, " err T"},     32'(bus.AlignErr),  32'h0);
        @(negedge Clk);
        check({tag, " stall T1"},  32'(bus.Stall),     32'h0);
        check({tag, " err T1"},    32'(bus.AlignErr),  32'h1);
        check({tag, " en T1"},     32'(bus.SramEn),    32'h0);
        check({tag, " valid T1"},  32'(bus.ReadValid), 32'h0);
        check({tag, " rdata T1"},  bus.ReadData,       keep_rd);
        clear_inputs();
        @(posedge Clk); #1;
        check({tag, " err T2"},    32'(bus.AlignErr),  32'h0);
        check({tag, " en T2"},     32'(bus.SramEn),    32'h0);
    endtask

    initial begin
        Reset_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge Clk);
        // A pending request while in reset must not raise Stall.
        bus.MemRead = 2'b11;
        bus.Address = 32'h10;
        @(negedge Clk);
        check_zero("reset");
        clear_inputs();
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        run_load("lw10", 2'b11, 32'h10, 32'd4, 32'h8899AABB);
        run_store("sb13", 2'b01, 32'h13, 32'h000000C5, 4'b1000, 32'hC5C5C5C5, 32'd4, 32'h8899AABB);
        run_load("lw10b", 2'b11, 32'h10, 32'd4, 32'hC599AABB);
        run_load("lb13", 2'b01, 32'h13, 32'd4, 32'hFFFFFFC5);
        run_load("lh10", 2'b10, 32'h10, 32'd4, 32'hFFFFAABB);
        run_load("lh12", 2'b10, 32'h12, 32'd4, 32'hFFFFC599);
        run_load("lb11", 2'b01, 32'h11, 32'd4, 32'hFFFFFFAA);

        run_err("lh11", 2'b10, 2'b00, 32'h11, 32'hFFFFFFAA);
        run_err("both", 2'b11, 2'b11, 32'h10, 32'hFFFFFFAA);
        run_err("lw12", 2'b11, 2'b00, 32'h12, 32'hFFFFFFAA);
        run_err("sh13", 2'b00, 2'b10, 32'h13, 32'hFFFFFFAA);

        run_store("sh22", 2'b10, 32'h22, 32'h00001234, 4'b1100, 32'h12341234, 32'd8, 32'hFFFFFFAA);
        run_load("lw20", 2'b11, 32'h20, 32'd8, 32'h12340000);
        run_load("lh22", 2'b10, 32'h22, 32'd8, 32'h00001234);
        run_load("lb20", 2'b01, 32'h20, 32'd8, 32'h00000000);

        // 0x1024 wraps onto word 9 of the 1024-word SRAM.
        run_store("sw1024", 2'b11, 32'h1024, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'd9, 32'h00000000);
        run_load("lw24", 2'b11, 32'h24, 32'd9, 32'hDEADBEEF);
        run_load("lb25", 2'b01, 32'h25, 32'd9, 32'hFFFFFFBE);

        // Reset during WAIT of a load discards it.
        bus.MemRead = 2'b11;
        bus.Address = 32'h10;
        @(negedge Clk);
        check("rst stall T",  32'(bus.Stall),  32'h1);
        @(negedge Clk);
        check("rst en T1",    32'(bus.SramEn), 32'h1);
        @(negedge Clk);
        check("rst stall T2", 32'(bus.Stall),  32'h1);
        Reset_n = 1'b0;
        #1;
        check_zero("rst mid");
        repeat (2) @(negedge Clk);
        check_zero("rst held");
        clear_inputs();
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        check("rst after valid", 32'(bus.ReadValid), 32'h0);
        check("rst after data",  bus.ReadData,       32'h0);
        run_load("lw10post", 2'b11, 32'h10, 32'd4, 32'hC599AABB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
